alu_issue_fifo: RTL

ALU_ISSUE_FIFO -- requirements
Module: alu_issue_fifo

---
 rtl/alu_issue_fifo.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_issue_fifo.sv
// rtl/alu_issue_fifo.sv - operand/opcode issue FIFO feeding the ALU stage (optional feature: ALU_ISSUE_OPFILTER_EN)
module alu_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [2:0]       out_opcode,
    output logic             out_en,
    output logic [CW-1:0]    count
`ifdef ALU_ISSUE_OPFILTER_EN
    ,
    output logic [7:0]       drop_count
`endif
);

    // Only LE (3'b001) is legal when the opcode filter is built in
    localparam logic [2:0] OP_LE = 3'b001;

    logic [WIDTH-1:0] mem_a_q  [DEPTH];
    logic [WIDTH-1:0] mem_b_q  [DEPTH];
    logic [2:0]       mem_op_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic accept;
    logic push;
    logic pop;

`ifdef ALU_ISSUE_OPFILTER_EN
    logic       drop;
    logic [7:0] drop_q, drop_d;
`endif

    // Handshake status comes from registered occupancy only, so in_ready never depends on out_ready
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_en    = out_valid;
    assign count     = count_q;

    // Head entry drives the ALU; outputs are forced to zero when nothing is queued
    assign out_a      = out_valid ? mem_a_q[rd_ptr_q]  : '0;
    assign out_b      = out_valid ? mem_b_q[rd_ptr_q]  : '0;
    assign out_opcode = out_valid ? mem_op_q[rd_ptr_q] : '0;

`ifdef ALU_ISSUE_OPFILTER_EN
    assign drop_count = drop_q;
`endif

    // Next-state: push/pop decode, pointer advance with wrap, occupancy update
    always_comb begin
        accept   = in_valid && in_ready;
        push     = accept;
`ifdef ALU_ISSUE_OPFILTER_EN
        push     = accept && (in_opcode == OP_LE);
        drop     = accept && (in_opcode != OP_LE);
        drop_d   = drop_q;
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
`endif
        pop      = out_valid && out_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards all entries by clearing pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef ALU_ISSUE_OPFILTER_EN
    // Saturating count of accepted-but-discarded illegal opcodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end
`endif

    // Entry storage is not reset; stale contents are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q]  <= in_a;
            mem_b_q[wr_ptr_q]  <= in_b;
            mem_op_q[wr_ptr_q] <= in_opcode;
        end
    end

endmodule
